// File: rtl/sdram_capture_writer.sv
// Capture-side SDRAM writer: packs byte pairs into 16-bit words, buffers them
// in a FIFO and writes them sequentially to SDRAM as an Avalon-MM write master.
module sdram_capture_writer #(
    parameter int unsigned        ADDR_W    = 25,
    parameter int unsigned        FIFO_AW   = 9,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = '1,
    parameter bit                 WRAP      = 1'b0
) (
    input  logic              M100CLK,
    input  logic              lock,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [7:0]        sample_in,
    output logic [ADDR_W-1:0] avm_address,
    output logic [1:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic [15:0]       avm_writedata,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        wrap_count,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

    localparam int unsigned      Depth    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    state_e              state_q, state_d;
    logic                phase_q, phase_d;
    logic [7:0]          byte_q, byte_d;
    logic                pipe_valid_q, pipe_valid_d;
    logic [15:0]         pipe_data_q, pipe_data_d;
    logic [FIFO_AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]    cnt_q, cnt_d;
    logic [15:0]         mem_q [Depth];
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          wrap_cnt_q, wrap_cnt_d;
    logic [ADDR_W-1:0]   words_q, words_d;

    logic accept, at_last, limit_hit, arm, flush, active;
    logic fifo_empty, full, take_byte, push, drop, pop;

    // Next-state, FIFO bookkeeping and output-stage control
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        byte_d       = byte_q;
        pipe_valid_d = 1'b0;
        pipe_data_d  = pipe_data_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        overflow_d   = overflow_q;
        wrap_cnt_d   = wrap_cnt_q;
        words_d      = words_q;

        accept     = write_q && !avm_waitrequest;
        at_last    = (addr_q == LAST_ADDR);
        limit_hit  = accept && at_last && !WRAP;
        arm        = (state_q == StIdle) && enable;
        // Arming restarts from empty; hitting the single-shot limit discards
        // anything still queued so nothing is written past LAST_ADDR.
        flush      = arm || limit_hit;
        active     = (state_q == StCapture) || (state_q == StDrain);
        fifo_empty = (cnt_q == '0);
        // The output stage counts toward capacity, so at most Depth words are
        // ever held between the packer and the bus.
        full       = (cnt_q + {{FIFO_AW{1'b0}}, write_q}) >= DepthCnt;
        take_byte  = (state_q == StCapture) && sample_valid && !limit_hit;
        push       = pipe_valid_q && !full && !flush;
        drop       = pipe_valid_q && full && !flush;
        pop        = active && !fifo_empty && (!write_q || accept) && !flush;

        case (state_q)
            StIdle:    if (enable) state_d = StCapture;
            StCapture: if (limit_hit || !enable) state_d = StDrain;
            StDrain:   if (fifo_empty && !pipe_valid_q && !write_q) state_d = StDone;
            StDone:    if (!enable) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (take_byte) begin
            if (!phase_q) begin
                byte_d  = sample_in;
                phase_d = 1'b1;
            end else begin
                pipe_valid_d = 1'b1;
                pipe_data_d  = {sample_in, byte_q};
                phase_d      = 1'b0;
            end
        end
        // Leaving capture discards an unpaired first byte
        if ((state_q == StCapture && state_d != StCapture) || arm) begin
            phase_d = 1'b0;
        end
        if (flush) begin
            pipe_valid_d = 1'b0;
        end

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop) overflow_d = 1'b1;

        if (accept) begin
            words_d = words_q + ADDR_W'(1);
            if (!at_last) begin
                addr_d = addr_q + ADDR_W'(1);
            end else if (WRAP) begin
                addr_d = BASE_ADDR;
                if (wrap_cnt_q != 8'hFF) wrap_cnt_d = wrap_cnt_q + 8'd1;
            end
        end

        if (pop) begin
            write_d = 1'b1;
            data_d  = mem_q[rptr_q];
        end else if (accept) begin
            write_d = 1'b0;
        end

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
        if (arm) begin
            addr_d     = BASE_ADDR;
            overflow_d = 1'b0;
            wrap_cnt_d = '0;
            words_d    = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge M100CLK) begin
        if (!lock) begin
            state_q      <= StIdle;
            phase_q      <= 1'b0;
            byte_q       <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= BASE_ADDR;
            data_q       <= '0;
            overflow_q   <= 1'b0;
            wrap_cnt_q   <= '0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            byte_q       <= byte_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            overflow_q   <= overflow_d;
            wrap_cnt_q   <= wrap_cnt_d;
            words_q      <= words_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge M100CLK) begin
        if (push) mem_q[wptr_q] <= pipe_data_q;
    end

    // Output drive
    always_comb begin
        avm_address    = addr_q;
        avm_write      = write_q;
        avm_chipselect = write_q;
        avm_byteenable = write_q ? 2'b11 : 2'b00;
        avm_writedata  = data_q;
        busy           = (state_q == StCapture) || (state_q == StDrain);
        done           = (state_q == StDone);
        overflow       = overflow_q;
        wrap_count     = wrap_cnt_q;
        words_written  = words_q;
    end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Scoreboard bench for sdram_capture_writer: stimulus pushes expected writes,
// per-instance monitors pop and compare on every accepted Avalon write.
module tb_sdram_capture_writer;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic lock;
    int   passed = 0;
    int   total  = 0;
    int   n;

    exp_t q_a[$];
    exp_t q_w[$];
    exp_t q_s[$];

    // Instance a: default addressing, 4-word FIFO
    logic        en_a, sv_a, wr_a;
    logic [7:0]  si_a;
    logic [24:0] addr_a, ww_a;
    logic [1:0]  be_a;
    logic        cs_a, w_a, busy_a, done_a, ovf_a;
    logic [15:0] wd_a;
    logic [7:0]  wc_a;
    // Instance w: circular 8..11
    logic        en_w, sv_w, wr_w;
    logic [7:0]  si_w;
    logic [24:0] addr_w, ww_w;
    logic [1:0]  be_w;
    logic        cs_w, w_w, busy_w, done_w, ovf_w;
    logic [15:0] wd_w;
    logic [7:0]  wc_w;
    // Instance s: single-shot 8..11
    logic        en_s, sv_s, wr_s;
    logic [7:0]  si_s;
    logic [24:0] addr_s, ww_s;
    logic [1:0]  be_s;
    logic        cs_s, w_s, busy_s, done_s, ovf_s;
    logic [15:0] wd_s;
    logic [7:0]  wc_s;

    sdram_capture_writer #(.FIFO_AW(2)) dut_a (
        .M100CLK(clk), .lock(lock), .enable(en_a), .sample_valid(sv_a), .sample_in(si_a),
        .avm_address(addr_a), .avm_byteenable(be_a), .avm_chipselect(cs_a),
        .avm_writedata(wd_a), .avm_write(w_a), .avm_waitrequest(wr_a), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .wrap_count(wc_a), .words_written(ww_a)
    );

    sdram_capture_writer #(
        .FIFO_AW(4), .BASE_ADDR(25'd8), .LAST_ADDR(25'd11), .WRAP(1'b1)
    ) dut_w (
        .M100CLK(clk), .lock(lock), .enable(en_w), .sample_valid(sv_w), .sample_in(si_w),
        .avm_address(addr_w), .avm_byteenable(be_w), .avm_chipselect(cs_w),
        .avm_writedata(wd_w), .avm_write(w_w), .avm_waitrequest(wr_w), .busy(busy_w),
        .done(done_w), .overflow(ovf_w), .wrap_count(wc_w), .words_written(ww_w)
    );

    sdram_capture_writer #(
        .FIFO_AW(4), .BASE_ADDR(25'd8), .LAST_ADDR(25'd11), .WRAP(1'b0)
    ) dut_s (
        .M100CLK(clk), .lock(lock), .enable(en_s), .sample_valid(sv_s), .sample_in(si_s),
        .avm_address(addr_s), .avm_byteenable(be_s), .avm_chipselect(cs_s),
        .avm_writedata(wd_s), .avm_write(w_s), .avm_waitrequest(wr_s), .busy(busy_s),
        .done(done_s), .overflow(ovf_s), .wrap_count(wc_s), .words_written(ww_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [24:0] a, input logic [15:0] d);
        total++;
        $display("FAIL %s: got write 0x%0h @0x%0h, expected no write", name, d, a);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int d, input logic [24:0] a, input logic [15:0] dt);
        exp_t e;
        e.addr = a;
        e.data = dt;
        case (d)
            0:       q_a.push_back(e);
            1:       q_w.push_back(e);
            default: q_s.push_back(e);
        endcase
    endtask

    task automatic send(input int d, input logic [7:0] b);
        case (d)
            0:       begin sv_a = 1'b1; si_a = b; end
            1:       begin sv_w = 1'b1; si_w = b; end
            default: begin sv_s = 1'b1; si_s = b; end
        endcase
        cyc(1);
        sv_a = 1'b0;
        sv_w = 1'b0;
        sv_s = 1'b0;
    endtask

    task automatic disarm_a();
        en_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin cyc(1); n++; end
        chk("disarm_done", done_a, 1);
        cyc(2);
        chk("disarm_idle", busy_a | done_a, 0);
    endtask

    // Monitors: a transfer is accepted at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (lock && w_a && !wr_a) begin
            if (q_a.size() == 0) unexpected("a_write", addr_a, wd_a);
            else begin
                e = q_a.pop_front();
                chk("a_addr", addr_a, e.addr);
                chk("a_data", wd_a, e.data);
                chk("a_be_cs", {be_a, cs_a}, 3'b111);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (lock && w_w && !wr_w) begin
            if (q_w.size() == 0) unexpected("w_write", addr_w, wd_w);
            else begin
                e = q_w.pop_front();
                chk("w_addr", addr_w, e.addr);
                chk("w_data", wd_w, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (lock && w_s && !wr_s) begin
            if (q_s.size() == 0) unexpected("s_write", addr_s, wd_s);
            else begin
                e = q_s.pop_front();
                chk("s_addr", addr_s, e.addr);
                chk("s_data", wd_s, e.data);
            end
        end
    end

    initial begin
        lock = 1'b0;
        en_a = 0; sv_a = 0; si_a = 0; wr_a = 0;
        en_w = 0; sv_w = 0; si_w = 0; wr_w = 0;
        en_s = 0; sv_s = 0; si_s = 0; wr_s = 0;
        cyc(3);

        // Reset values
        chk("rst_write", w_a, 0);
        chk("rst_cs", cs_a, 0);
        chk("rst_be", be_a, 0);
        chk("rst_data", wd_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_busy_done", {busy_a, done_a}, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_wrap", wc_a, 0);
        chk("rst_words", ww_a, 0);
        chk("rst_addr_base8", addr_w, 8);
        lock = 1'b1;
        cyc(1);

        // Basic packing, latency and back-to-back stream
        en_a = 1'b1;
        cyc(1);
        chk("t1_busy", busy_a, 1);
        expect_wr(0, 25'd0, 16'h2211);
        expect_wr(0, 25'd1, 16'h4433);
        send(0, 8'h11);
        send(0, 8'h22);
        chk("t1_lat_edge0", w_a, 0);
        send(0, 8'h33);
        chk("t1_lat_edge1", w_a, 0);
        send(0, 8'h44);
        chk("t1_lat_edge2", w_a, 1);
        cyc(6);
        chk("t1_words", ww_a, 2);
        chk("t1_sb_empty", q_a.size(), 0);
        disarm_a();

        // Waitrequest stall holds address and data
        wr_a = 1'b1;
        en_a = 1'b1;
        cyc(1);
        expect_wr(0, 25'd0, 16'h2211);
        send(0, 8'h11);
        send(0, 8'h22);
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_write", w_a, 1);
            chk("t2_hold_addr", addr_a, 0);
            chk("t2_hold_data", wd_a, 16'h2211);
            cyc(1);
        end
        wr_a = 1'b0;
        cyc(4);
        chk("t2_words", ww_a, 1);
        chk("t2_sb_empty", q_a.size(), 0);
        disarm_a();

        // Overflow with a 4-word buffer
        wr_a = 1'b1;
        en_a = 1'b1;
        cyc(1);
        expect_wr(0, 25'd0, 16'h0201);
        expect_wr(0, 25'd1, 16'h0403);
        expect_wr(0, 25'd2, 16'h0605);
        expect_wr(0, 25'd3, 16'h0807);
        for (int k = 1; k <= 12; k++) send(0, 8'(k));
        cyc(4);
        chk("t3_overflow", ovf_a, 1);
        chk("t3_words_stalled", ww_a, 0);
        wr_a = 1'b0;
        cyc(12);
        chk("t3_words", ww_a, 4);
        chk("t3_sb_empty", q_a.size(), 0);
        chk("t3_overflow_sticky", ovf_a, 1);
        disarm_a();

        // Odd byte dropped on disable, DRAIN -> DONE -> IDLE
        en_a = 1'b1;
        cyc(1);
        chk("t5_overflow_cleared", ovf_a, 0);
        chk("t5_words_cleared", ww_a, 0);
        expect_wr(0, 25'd0, 16'h2211);
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        en_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin cyc(1); n++; end
        chk("t5_done", done_a, 1);
        cyc(1);
        chk("t5_done_one_cycle", done_a, 0);
        chk("t5_idle_busy", busy_a, 0);
        chk("t5_words", ww_a, 1);
        chk("t5_sb_empty", q_a.size(), 0);

        // Circular buffer 8..11
        en_w = 1'b1;
        cyc(1);
        expect_wr(1, 25'd8,  16'h1110);
        expect_wr(1, 25'd9,  16'h1312);
        expect_wr(1, 25'd10, 16'h1514);
        expect_wr(1, 25'd11, 16'h1716);
        expect_wr(1, 25'd8,  16'h1918);
        expect_wr(1, 25'd9,  16'h1B1A);
        for (int k = 0; k < 12; k++) send(1, 8'(8'h10 + k));
        cyc(10);
        chk("t4_wrap_count", wc_w, 1);
        chk("t4_words", ww_w, 6);
        chk("t4_sb_empty", q_w.size(), 0);

        // Single-shot 8..11 stops after LAST_ADDR
        en_s = 1'b1;
        cyc(1);
        expect_wr(2, 25'd8,  16'h1110);
        expect_wr(2, 25'd9,  16'h1312);
        expect_wr(2, 25'd10, 16'h1514);
        expect_wr(2, 25'd11, 16'h1716);
        for (int k = 0; k < 12; k++) send(2, 8'(8'h10 + k));
        n = 0;
        while (!done_s && n < 40) begin cyc(1); n++; end
        chk("t6_done", done_s, 1);
        for (int k = 0; k < 4; k++) send(2, 8'(8'hA0 + k));
        cyc(6);
        chk("t6_words", ww_s, 4);
        chk("t6_done_held", done_s, 1);
        chk("t6_wrap_count", wc_s, 0);
        chk("t6_sb_empty", q_s.size(), 0);

        // Reset during an outstanding write
        wr_a = 1'b1;
        en_a = 1'b1;
        cyc(1);
        send(0, 8'h55);
        send(0, 8'h66);
        n = 0;
        while (!w_a && n < 10) begin cyc(1); n++; end
        chk("t7_write_pending", w_a, 1);
        lock = 1'b0;
        cyc(1);
        chk("t7_write", w_a, 0);
        chk("t7_cs_be", {cs_a, be_a}, 0);
        chk("t7_data", wd_a, 0);
        chk("t7_addr", addr_a, 0);
        chk("t7_busy_done", {busy_a, done_a}, 0);
        chk("t7_ovf_wrap", {ovf_a, wc_a}, 0);
        chk("t7_words", ww_a, 0);
        lock = 1'b1;
        wr_a = 1'b0;
        en_a = 1'b0;
        en_w = 1'b0;
        en_s = 1'b0;
        cyc(4);
        chk("t7_no_resume", w_a, 0);
        chk("t7_sb_empty", q_a.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdram_capture_writer.md
Name: sdram_capture_writer

Overview:
- Capture-side counterpart of the SDRAM playback reader: the DRFM record path.
- Accepts an 8-bit sample stream and packs byte pairs into 16-bit words.
- Buffers the words in an internal FIFO, then writes them sequentially into SDRAM as an Avalon-MM write master.
- Sits in front of the SDRAM controller mux in the write slot. Its write port is active-high; any inversion toward the controller happens at the mux.

Parameters:
- ADDR_W, 25, Avalon word-address width.
- FIFO_AW, 9, log2 of FIFO depth in 16-bit words (default 512).
- BASE_ADDR, 0, first SDRAM word address of a capture.
- LAST_ADDR, 25'h1FFFFFF, last SDRAM word address of a capture (inclusive); must be >= BASE_ADDR.
- WRAP, 0, 1 = circular buffer, 0 = single-shot.

Ports:
- M100CLK  in  1  system clock; all logic on rising edge.
- lock  in  1  reset, synchronous, active-low.
- enable  in  1  level; arms and holds a capture.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_in  in  8  sample byte.
- avm_address  out  ADDR_W  write word address.
- avm_byteenable  out  2  always 2'b11 while avm_write is high.
- avm_chipselect  out  1  equals avm_write.
- avm_writedata  out  16  {second byte, first byte}.
- avm_write  out  1  write request.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky: at least one word was dropped.
- wrap_count  out  8  completed wraps; saturates at 255.
- words_written  out  ADDR_W  accepted writes since arm; wraps modulo 2^ADDR_W.

Behaviour:
- Reset (lock=0 at an edge):
  - State goes to IDLE; FIFO, pack register and pair-phase are cleared.
  - Outputs reset to: avm_write=0, avm_chipselect=0, avm_byteenable=0, avm_writedata=0, avm_address=BASE_ADDR, busy=0, done=0, overflow=0, wrap_count=0, words_written=0.
  - Reset during an outstanding write abandons it; avm_write is 0 in the following cycle.
- States: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE -> CAPTURE when enable=1. On this transition address returns to BASE_ADDR, counters and overflow clear, pair-phase clears, and the FIFO empties.
  - CAPTURE -> DRAIN when enable=0. A pending unpaired first byte is discarded.
  - CAPTURE -> DRAIN when WRAP=0 and the write to LAST_ADDR is accepted. Further samples are ignored from then on.
  - DRAIN -> DONE when the FIFO is empty and no write is outstanding.
  - DONE -> IDLE when enable=0.
- Packing:
  - Only in CAPTURE, on sample_valid=1.
  - Phase 0: latch the byte and set phase to 1.
  - Phase 1: push {sample_in, latched byte} into the FIFO and set phase to 0.
  - If the FIFO is full at the push, drop the word, set overflow=1, and still toggle the phase.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Avalon write:
  - If the FIFO was empty and the output stage idle, avm_write rises 2 clocks after the edge that sampled the second byte.
  - While avm_write=1 and avm_waitrequest=1, address, data and byteenable are held stable.
  - A transfer is accepted on an edge with avm_write=1 and avm_waitrequest=0.
  - On acceptance: words_written increments. If another word is available in the FIFO, the next word loads with no idle cycle (back-to-back writes); otherwise avm_write drops.
- Address:
  - Increments by 1 per accepted write.
  - After an accepted write at LAST_ADDR: WRAP=1 wraps to BASE_ADDR and increments wrap_count; WRAP=0 ends the capture (state goes to DRAIN).
- Edge cases:
  - A waitrequest held high indefinitely stalls the writer; the FIFO keeps filling and overflows per the packing rule.
  - An enable toggle while in DRAIN does not re-arm the block; arming happens only from IDLE.

Test Plan:
- Reset then enable=1, bytes 0x11,0x22,0x33,0x44 back-to-back, waitrequest=0 -> writes 0x2211 @0 and 0x4433 @1; first avm_write 2 clocks after the 0x22 edge; words_written=2.
- waitrequest held high 5 cycles during the first write -> avm_address=0 and avm_writedata=0x2211 stable throughout; exactly one acceptance; no duplicate or skipped address.
- FIFO_AW=2, waitrequest=1, push 6 word pairs -> 4 words buffered, overflow=1; release waitrequest -> exactly those 4 words written in order at addresses 0..3.
- WRAP=1, BASE_ADDR=8, LAST_ADDR=11, 6 words -> addresses 8,9,10,11,8,9; wrap_count=1. WRAP=0, same settings -> 4 writes, then done=1 and later samples ignored.
- Deassert enable after 3 bytes -> one write (0x2211), odd byte 0x33 dropped, DRAIN then DONE with done=1 for 1 cycle, then IDLE. Assert lock=0 mid-write -> next cycle avm_write=0 and all outputs at reset values.
